id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and EX-stage operand selector of the five-stage pipeline CPU. It latches decoded operands and control signals from ID, applies stall/flush/bubble rules, and drives the `A`, `B`, `ALUOP` and `CS_CanOverflow` inputs of the ALU directly. It also resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by load-use bubble insertion.

## Interface
Parameters:
- none; widths are fixed (32-bit datapath, 5-bit register numbers, 6-bit ALUOP from `includes/ALUOP.vh`)

Ports (reset is asynchronous and active-high; one clock):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all latched contents
- flush  in  1  replace next contents with bubble
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  source/destination register numbers
- id_rs_data, id_rt_data  in  32 each  register file read data
- id_imm  in  32  already-extended immediate
- id_ALUOP  in  6  ALU operation code
- id_CS_ALUSrc  in  1  1 = B takes immediate
- id_CS_CanOverflow, id_CS_RegWrite, id_CS_MemRead, id_CS_MemWrite  in  1 each  control bits
- exmem_RegWrite  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source
- memwb_RegWrite  in  1, memwb_rd  in  5, memwb_data  in  32  MEM/WB forwarding source
- A, B  out  32 each  ALU operands
- ALUOP  out  6; CS_CanOverflow  out  1  to ALU
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite  out  1 each
- ex_rd  out  5; ex_store_data  out  32  forwarded rt value for stores
- hazard_stall  out  1  to hazard unit: freeze PC and IF/ID this cycle

## Operation
- Latched fields: valid, rs, rt, rd, rs_data, rt_data, imm, ALUOP, ALUSrc, CanOverflow, RegWrite, MemRead, MemWrite.
- Per-edge priority: flush > stall > hazard bubble > normal load.
  - flush: load bubble.
  - stall: hold everything.
  - hazard_stall: load bubble.
  - Otherwise: load ID fields.
- Bubble contents: valid=0, RegWrite=MemRead=MemWrite=CanOverflow=ALUSrc=0, ALUOP=`ALU_ADD`, rs=rt=rd=0, data/imm=0.
- Forwarding is combinational and evaluated every cycle, including while stalled. Operand value selection:
  - EX/MEM result if exmem_RegWrite, exmem_rd≠0 and exmem_rd equals the latched rs/rt.
  - Otherwise MEM/WB data under the same conditions.
  - Otherwise the latched value.
  - EX/MEM has priority when both match.
- A = forwarded rs value.
- B = imm if ALUSrc, else forwarded rt value.
- ex_store_data = forwarded rt value, always, regardless of ALUSrc.
- hazard_stall = ex_valid & ex_MemRead & ex_rd≠0 & (ex_rd==id_rs | ex_rd==id_rt) & id_valid. It is combinational.
- Register 0 is never forwarded and never causes a hazard.

## Timing
- Reset (asynchronous): every latched field takes its bubble value immediately. Outputs during reset:
  - A=0, B=0, ALUOP=`ALU_ADD`.
  - All control outputs 0; hazard_stall=0.
- Latency: ID fields appear on the outputs one cycle after the capturing edge. Forwarding adds no cycles.
- A load-use hazard costs exactly one bubble. The cycle after it, the load sits in MEM/WB and the dependent instruction captures normally, then forwards from MEM/WB.
- Reset deasserted mid-stream: the first edge after deassertion follows the normal priority rules.
- flush and stall asserted together: flush wins and a bubble is loaded.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding as above.
- `ID_EX_FORWARD_EN` undefined:
  - A, B and ex_store_data use latched register values only; forwarding inputs are ignored.
  - hazard_stall additionally asserts when id_valid and id_rs/id_rt (nonzero) matches ex_rd with ex_RegWrite, or exmem_rd with exmem_RegWrite.
  - The register file is write-first, so MEM/WB needs no stall.

## Test plan
- Reset: assert rst with id_valid=1 loaded → A=0, B=0, ALUOP=`ALU_ADD`, ex_valid=0 immediately, asynchronously.
- Dependent ADD: ADD r3 (EX/MEM result 32'h0000_0010) followed by ADD r4,r3,r5 with r5=5 → A=32'h10 (EX/MEM forward), B=5.
- Double match: exmem_rd=memwb_rd=7, exmem_result=1, memwb_data=2, latched rs=7 → A=1 (EX/MEM priority).
- Load-use: LW r2 in EX, ID has rs=2 → hazard_stall=1 for one cycle, bubble loaded (ex_valid=0). Next cycle A=memwb_data.
- r0 guard: exmem_rd=0 with RegWrite=1, exmem_result=32'hFFFF_FFFF, rs=0 → A=latched 0.
- Control priority: stall=1 and flush=1 on the same edge → bubble. Then stall=1 alone → contents held, and A follows a changing exmem_result while held.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register plus EX-stage operand selection.
//
// Latches decoded operands and control bits from ID. Applies flush / stall /
// hazard-bubble rules on each edge. Drives the ALU operands A and B, ALUOP and
// CS_CanOverflow directly. Read-after-write hazards are resolved by
// forwarding from EX/MEM and MEM/WB, or by inserting a load-use bubble.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   : operands are forwarded from EX/MEM (priority)
//                                 and MEM/WB; only load-use hazards stall.
//                     undefined : operands come from the latched register
//                                 values only; any RAW dependency on the
//                                 instruction in EX or EX/MEM stalls ID instead.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   stall, flush                hold contents / replace next contents with bubble
//   id_*                        decoded instruction fields from ID
//   exmem_*, memwb_*            forwarding sources (writeback enable, rd, value)
//   A, B, ALUOP, CS_CanOverflow ALU inputs
//   ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd
//                               control state of the instruction in EX
//   ex_store_data               forwarded rt value used by stores
//   hazard_stall                freeze PC and IF/ID this cycle
// ----------------------------------------------------------------------------
`ifndef ALU_ADD
`define ALU_ADD 6'h20
`endif

module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [5:0]  id_ALUOP,
  input  logic        id_CS_ALUSrc,
  input  logic        id_CS_CanOverflow,
  input  logic        id_CS_RegWrite,
  input  logic        id_CS_MemRead,
  input  logic        id_CS_MemWrite,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [5:0]  ALUOP,
  output logic        CS_CanOverflow,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        hazard_stall
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [5:0]  aluop;
    logic        alusrc;
    logic        can_ovf;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  // A bubble is a harmless ADD that writes nothing and touches no memory.
  localparam id_ex_t BUBBLE = '{
    valid:     1'b0,
    rs:        5'd0,
    rt:        5'd0,
    rd:        5'd0,
    rs_data:   32'd0,
    rt_data:   32'd0,
    imm:       32'd0,
    aluop:     `ALU_ADD,
    alusrc:    1'b0,
    can_ovf:   1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

  id_ex_t ex_q, ex_d, id_in;
  logic [31:0] rs_fwd, rt_fwd;
  logic        load_use, raw_dep;

  assign id_in = '{
    valid:     id_valid,
    rs:        id_rs,
    rt:        id_rt,
    rd:        id_rd,
    rs_data:   id_rs_data,
    rt_data:   id_rt_data,
    imm:       id_imm,
    aluop:     id_ALUOP,
    alusrc:    id_CS_ALUSrc,
    can_ovf:   id_CS_CanOverflow,
    reg_write: id_CS_RegWrite,
    mem_read:  id_CS_MemRead,
    mem_write: id_CS_MemWrite
  };

  // Operand forwarding. Evaluated every cycle, so a held (stalled) instruction
  // still picks up the newest producer value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rs_fwd = ex_q.rs_data;
    rt_fwd = ex_q.rt_data;
`ifdef ID_EX_FORWARD_EN
    // MEM/WB is checked first and EX/MEM overrides it: the younger producer wins.
    if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs)) rs_fwd = memwb_data;
    if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rt)) rt_fwd = memwb_data;
    if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs)) rs_fwd = exmem_result;
    if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rt)) rt_fwd = exmem_result;
`endif
  end

`ifndef ID_EX_FORWARD_EN
  // Forwarding values are not consumed in this build.
  logic unused_fwd;
  assign unused_fwd = &{1'b0, exmem_result, memwb_RegWrite, memwb_rd, memwb_data};
`endif

  // A load in EX has no result yet, so a consumer in ID must wait one cycle.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == id_rs) || (ex_q.rd == id_rt)) && id_valid;

`ifdef ID_EX_FORWARD_EN
  assign raw_dep = 1'b0;
`else
  // Without forwarding, wait until the producer has left EX/MEM; the register
  // file is write-first, so a producer in MEM/WB is already visible.
  assign raw_dep = id_valid && (
      ((id_rs != 5'd0) && ((ex_q.reg_write && (ex_q.rd == id_rs)) ||
                           (exmem_RegWrite && (exmem_rd == id_rs)))) ||
      ((id_rt != 5'd0) && ((ex_q.reg_write && (ex_q.rd == id_rt)) ||
                           (exmem_RegWrite && (exmem_rd == id_rt)))));
`endif

  // Held low during reset so the front end is never frozen by stale ID inputs.
  assign hazard_stall = !rst && (load_use || raw_dep);

  // Next-state selection: flush > stall > hazard bubble > normal load.
  always_comb begin
    ex_d = id_in;
    if (flush)             ex_d = BUBBLE;
    else if (stall)        ex_d = ex_q;
    else if (hazard_stall) ex_d = BUBBLE;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs as they were just before the edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the whole pipeline register is reset, not just valid, so the ALU
    // sees defined operands and ALUOP while rst is still asserted.
    if (rst) ex_q <= BUBBLE;
    else     ex_q <= ex_d;
  end

  assign A              = rs_fwd;
  assign B              = ex_q.alusrc ? ex_q.imm : rt_fwd;
  assign ex_store_data  = rt_fwd;
  assign ALUOP          = ex_q.aluop;
  assign CS_CanOverflow = ex_q.can_ovf;
  assign ex_valid       = ex_q.valid;
  assign ex_RegWrite    = ex_q.reg_write;
  assign ex_MemRead     = ex_q.mem_read;
  assign ex_MemWrite    = ex_q.mem_write;
  assign ex_rd          = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// Directed scenarios (reset, forwarding, double match, load-use, r0 guard,
// control priority) followed by randomized traffic, all compared against a
// transaction-level reference model. Honours ID_EX_FORWARD_EN like the design.
// ----------------------------------------------------------------------------
`ifndef ALU_ADD
`define ALU_ADD 6'h20
`endif

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_ALUOP;
  logic        id_CS_ALUSrc, id_CS_CanOverflow, id_CS_RegWrite, id_CS_MemRead, id_CS_MemWrite;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] A, B, ex_store_data;
  logic [5:0]  ALUOP;
  logic        CS_CanOverflow, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, hazard_stall;
  logic [4:0]  ex_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ALUOP(id_ALUOP), .id_CS_ALUSrc(id_CS_ALUSrc),
    .id_CS_CanOverflow(id_CS_CanOverflow), .id_CS_RegWrite(id_CS_RegWrite),
    .id_CS_MemRead(id_CS_MemRead), .id_CS_MemWrite(id_CS_MemWrite),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .A(A), .B(B), .ALUOP(ALUOP), .CS_CanOverflow(CS_CanOverflow),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .hazard_stall(hazard_stall)
  );

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit        v;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit [5:0]  op;
    bit        src, ov, rw, mr, mw;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    b.op = `ALU_ADD;
    return b;
  endfunction

  function automatic instr_t from_id();
    instr_t t;
    t.v = id_valid; t.rs = id_rs; t.rt = id_rt; t.rd = id_rd;
    t.rsd = id_rs_data; t.rtd = id_rt_data; t.imm = id_imm; t.op = id_ALUOP;
    t.src = id_CS_ALUSrc; t.ov = id_CS_CanOverflow; t.rw = id_CS_RegWrite;
    t.mr = id_CS_MemRead; t.mw = id_CS_MemWrite;
    return t;
  endfunction

  // Value of register r as seen by the EX instruction.
  function automatic logic [31:0] reg_val(logic [4:0] r, logic [31:0] latched);
`ifdef ID_EX_FORWARD_EN
    if (r != 0 && exmem_RegWrite && exmem_rd == r) return exmem_result;
    if (r != 0 && memwb_RegWrite && memwb_rd == r) return memwb_data;
`endif
    return latched;
  endfunction

  // Does the ID instruction read register r (nonzero)?
  function automatic bit id_reads(logic [4:0] r);
    return id_valid && r != 0 && (id_rs == r || id_rt == r);
  endfunction

  function automatic bit exp_hazard();
    bit h;
    if (rst) return 1'b0;
    h = m.v && m.mr && id_reads(m.rd);
`ifndef ID_EX_FORWARD_EN
    if (m.rw && id_reads(m.rd)) h = 1'b1;
    if (exmem_RegWrite && id_reads(exmem_rd)) h = 1'b1;
`endif
    return h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".A"},      A, reg_val(m.rs, m.rsd));
    check({ph, ".B"},      B, m.src ? m.imm : reg_val(m.rt, m.rtd));
    check({ph, ".store"},  ex_store_data, reg_val(m.rt, m.rtd));
    check({ph, ".ALUOP"},  {26'd0, ALUOP}, {26'd0, m.op});
    check({ph, ".ovf"},    {31'd0, CS_CanOverflow}, {31'd0, m.ov});
    check({ph, ".valid"},  {31'd0, ex_valid}, {31'd0, m.v});
    check({ph, ".rw"},     {31'd0, ex_RegWrite}, {31'd0, m.rw});
    check({ph, ".mr"},     {31'd0, ex_MemRead}, {31'd0, m.mr});
    check({ph, ".mw"},     {31'd0, ex_MemWrite}, {31'd0, m.mw});
    check({ph, ".rd"},     {27'd0, ex_rd}, {27'd0, m.rd});
    check({ph, ".hazard"}, {31'd0, hazard_stall}, {31'd0, exp_hazard()});
  endtask

  // Called 1 time unit after a rising edge: check mid-cycle, then clock.
  task automatic step(input string ph);
    instr_t nxt;
    #4;
    check_all(ph);
    if (flush)             nxt = bubble();
    else if (stall)        nxt = m;
    else if (exp_hazard()) nxt = bubble();
    else                   nxt = from_id();
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit [5:0] op, input bit src, input bit ov, input bit rw,
                        input bit mr, input bit mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ALUOP = op;
    id_CS_ALUSrc = src; id_CS_CanOverflow = ov; id_CS_RegWrite = rw;
    id_CS_MemRead = mr; id_CS_MemWrite = mw;
  endtask

  task automatic set_fwd(input bit erw, input bit [4:0] erd, input bit [31:0] eres,
                         input bit mrw, input bit [4:0] mrd, input bit [31:0] mdat);
    exmem_RegWrite = erw; exmem_rd = erd; exmem_result = eres;
    memwb_RegWrite = mrw; memwb_rd = mrd; memwb_data = mdat;
  endtask

  initial begin
    m = bubble();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd9, 5'd10, 5'd11, 32'h1111_1111, 32'h2222_2222, 32'h33, 6'h05, 0, 1, 1, 0, 0);
    // Edges under reset must not load ID.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Load a real instruction, then assert reset asynchronously mid-cycle.
    step("load");
    check_all("loaded");
    #2 rst = 1'b1;
    #1;
    m = bubble();
    check_all("async_rst");
    #1 rst = 1'b0;

    // Dependent ADD: ADD r4,r3,r5 with r3 produced in EX/MEM.
    set_id(1, 5'd3, 5'd5, 5'd4, 32'h0, 32'h5, 32'h0, `ALU_ADD, 0, 1, 1, 0, 0);
    step("dep_cap");
    set_id(0, 0, 0, 0, 0, 0, 0, `ALU_ADD, 0, 0, 0, 0, 0);
    set_fwd(1, 5'd3, 32'h0000_0010, 0, 0, 0);
    step("dep_add");

    // Double match: EX/MEM and MEM/WB both write r7.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd7, 5'd7, 5'd1, 32'hDEAD_0007, 32'hBEEF_0007, 32'h0, `ALU_ADD, 0, 0, 1, 0, 0);
    step("dbl_cap");
    set_id(0, 0, 0, 0, 0, 0, 0, `ALU_ADD, 0, 0, 0, 0, 0);
    set_fwd(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    step("dbl_match");

    // r0 guard.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, `ALU_ADD, 0, 0, 1, 0, 0);
    step("r0_cap");
    set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
    step("r0_guard");

    // Load-use: LW r2 in EX, dependent ADD r8,r2,r6 in ID.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 32'h4, `ALU_ADD, 1, 0, 1, 1, 0);
    step("lw_cap");
    set_id(1, 5'd2, 5'd6, 5'd8, 32'h0, 32'h3, 32'h0, `ALU_ADD, 0, 1, 1, 0, 0);
    step("lu_bubble");
    step("lu_capture");
    set_id(0, 0, 0, 0, 0, 0, 0, `ALU_ADD, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 1, 5'd2, 32'h0000_ABCD);
    step("lu_fwd");

    // Control priority: flush+stall gives a bubble, then stall holds.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd12, 5'd13, 5'd14, 32'hA, 32'hB, 32'hC, 6'h11, 1, 1, 1, 0, 1);
    step("prio_cap");
    stall = 1'b1; flush = 1'b1;
    set_id(1, 5'd15, 5'd16, 5'd17, 32'h15, 32'h16, 32'h17, 6'h12, 0, 1, 1, 0, 0);
    step("prio_both");
    stall = 1'b0; flush = 1'b0;
    step("prio_load");
    stall = 1'b1;
    set_id(1, 5'd18, 5'd19, 5'd20, 32'h18, 32'h19, 32'h20, 6'h13, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_fwd(1, 5'd15, 32'h5000 + i, 0, 0, 0);
      step("prio_hold");
    end
    stall = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    step("prio_release");

    // Randomized traffic on a small register window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      set_id($urandom_range(3) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), $urandom, $urandom, $urandom, 6'($urandom_range(63)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             ($urandom_range(3) == 0), 1'($urandom_range(1)));
      set_fwd(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
              1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
